modport_top: RTL and testbench
==============================

MODPORT_TOP -- requirements
Module: modport_top

Interface
REQ-001 The block SHALL expose the parameter ADDR_W, default `ADDR_WIDTH (32), as the address width.
REQ-002 The block SHALL expose the parameter DATA_W, default `DATA_WIDTH (32), as the data width.
REQ-003 The block SHALL expose the parameter BASE_ADDR, default 32'h0000_0000, as the lowest permitted address (inclusive).
REQ-004 The block SHALL expose the parameter LIMIT_ADDR, default 32'h0000_FFFF, as the highest permitted address (inclusive).
REQ-005 hclk  in  1  sole clock; all logic on rising edge.
REQ-006 hresetn  in  1  synchronous, active-high reset (asserted = 1) despite legacy name.
REQ-007 s_hsel  in  1  upstream slave select.
REQ-008 s_htrans  in  2  upstream transfer type (00 IDLE, 01 BUSY, 10 NONSEQ, 11 SEQ).
REQ-009 s_hburst / s_hsize  in  3 / 3  upstream burst, size.
REQ-010 s_hwrite  in  1  upstream direction (1 = write).
REQ-011 s_haddr  in  ADDR_W  upstream address.
REQ-012 s_hwdata  in  DATA_W  upstream write data.
REQ-013 s_hrdata  out  DATA_W  read data to master.
REQ-014 s_hready  out  1  transfer-done to master.
REQ-015 s_hresp  out  2  response to master (00 OKAY, 01 ERROR).
REQ-016 m_hsel, m_htrans, m_hburst, m_hsize, m_hwrite, m_haddr, m_hwdata  out  1/2/3/3/1/ADDR_W/DATA_W  downstream copies of upstream signals.
REQ-017 m_hrdata / m_hready / m_hresp  in  DATA_W/1/2  downstream slave return signals.

Function
REQ-018 A transfer is valid when s_hsel=1, s_htrans[1]=1 (NONSEQ or SEQ), and s_hready=1.
REQ-019 Address check: pass when BASE_ADDR <= s_haddr <= LIMIT_ADDR, compared unsigned at full ADDR_W; each burst beat is checked independently.
REQ-020 The FSM SHALL have the states IDLE, FWD, ERR1, ERR2.
REQ-021 A valid passing transfer SHALL be forwarded combinationally: m_* = s_*, m_hsel=1; FSM goes to FWD.
REQ-022 A valid failing transfer SHALL drive m_htrans=00 and m_hsel=0 in that cycle, and the FSM SHALL go to ERR1.
REQ-023 In FWD: s_hready=m_hready, s_hresp=m_hresp, s_hrdata=m_hrdata; the FSM SHALL hold FWD until m_hready=1, then evaluate the next address phase in the same cycle.
REQ-024 In ERR1: s_hready=0, s_hresp=01, no forwarding; the FSM SHALL always go to ERR2.
REQ-025 In ERR2: s_hready=1, s_hresp=01, s_hrdata=0; an address phase in this cycle SHALL be evaluated like in IDLE.
REQ-026 In IDLE, or for IDLE/BUSY/unselected transfers: s_hready=1, s_hresp=00, s_hrdata=0, m_htrans=00; no wait states.
REQ-027 m_hwdata SHALL always equal s_hwdata (data-phase pass-through); blocked writes SHALL never reach downstream because no address phase is issued.
REQ-028 Latency: passing transfers add zero cycles; blocked transfers take exactly two data-phase cycles.

Reset
REQ-029 While hresetn=1 at a clock edge, the FSM SHALL go to IDLE, giving s_hready=1, s_hresp=00, s_hrdata=0, m_htrans=00, m_hsel=0 (and blocked_cnt=0 when present).
REQ-030 A reset mid-transfer (FWD or ERR1/ERR2) SHALL abort it with no further response.

Configuration
REQ-031 With ADDR_FILTER_STATS_EN defined: the block SHALL add output blocked_cnt[15:0], which increments on each blocked transfer, saturates at 16'hFFFF, and clears on reset.
REQ-032 Without ADDR_FILTER_STATS_EN: the port and counter SHALL be absent, with identical bus behaviour.

Verification
REQ-033 Reset held for 2 cycles -> s_hready=1, s_hresp=00, m_htrans=00.
REQ-034 NONSEQ write to 0x0000_0010, data 0xDEADBEEF, m_hready=1 -> m_haddr=0x10, m_hwdata=0xDEADBEEF, s_hresp=00, zero waits.
REQ-035 NONSEQ read from 0x0001_0000 -> m_htrans=00, then s_hready=0/s_hresp=01, then s_hready=1/s_hresp=01, s_hrdata=0.
REQ-036 Read from 0x0000_FFFF with m_hready low for 2 cycles, then m_hrdata=0x12345678 -> s_hready low 2 cycles, then s_hrdata=0x12345678.
REQ-037 INCR4 burst from 0x0000_FFF8 -> beats 0xFFF8 and 0xFFFC forwarded, beat 0x1_0000 gets ERROR (blocked_cnt=1 with macro).

Source files
------------

// File: rtl/modport_top.sv
// AHB-Lite address-window filter: forwards transfers inside [BASE_ADDR, LIMIT_ADDR], answers others with a two-cycle ERROR.
// Optional blocked-transfer counter under `define ADDR_FILTER_STATS_EN.
`ifndef ADDR_WIDTH
`define ADDR_WIDTH 32
`endif
`ifndef DATA_WIDTH
`define DATA_WIDTH 32
`endif

module modport_top #(
  parameter int                ADDR_W     = `ADDR_WIDTH,
  parameter int                DATA_W     = `DATA_WIDTH,
  parameter logic [ADDR_W-1:0] BASE_ADDR  = 32'h0000_0000,
  parameter logic [ADDR_W-1:0] LIMIT_ADDR = 32'h0000_FFFF
) (
  input  logic              hclk,
  input  logic              hresetn,
  input  logic              s_hsel,
  input  logic [1:0]        s_htrans,
  input  logic [2:0]        s_hburst,
  input  logic [2:0]        s_hsize,
  input  logic              s_hwrite,
  input  logic [ADDR_W-1:0] s_haddr,
  input  logic [DATA_W-1:0] s_hwdata,
  output logic [DATA_W-1:0] s_hrdata,
  output logic              s_hready,
  output logic [1:0]        s_hresp,
  output logic              m_hsel,
  output logic [1:0]        m_htrans,
  output logic [2:0]        m_hburst,
  output logic [2:0]        m_hsize,
  output logic              m_hwrite,
  output logic [ADDR_W-1:0] m_haddr,
  output logic [DATA_W-1:0] m_hwdata,
  input  logic [DATA_W-1:0] m_hrdata,
  input  logic              m_hready,
  input  logic [1:0]        m_hresp,
`ifdef ADDR_FILTER_STATS_EN
  output logic [15:0]       blocked_cnt,
`endif
  output logic [1:0]        fsm_state
);

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    FWD  = 2'd1,
    ERR1 = 2'd2,
    ERR2 = 2'd3
  } state_t;

  state_t state, state_nxt;

  // Window test as one unsigned compare: (addr - base) wraps above the span when addr < base.
  localparam logic [ADDR_W-1:0] SPAN = LIMIT_ADDR - BASE_ADDR;

  logic [ADDR_W-1:0] offset;
  logic              addr_ok;
  logic              xfer_valid;

  assign offset  = s_haddr - BASE_ADDR;
  assign addr_ok = (offset <= SPAN);

  // Handshake: an address phase is taken when s_hsel & s_htrans[1] & s_hready are all high;
  // the previous data phase completes in the same cycle, so s_hready doubles as the accept strobe.
  assign xfer_valid = s_hsel & s_htrans[1] & s_hready;

  assign fsm_state = state;

  always_ff @(posedge hclk) begin
    if (hresetn) state <= IDLE;
    else         state <= state_nxt;
  end

  always_comb begin
    state_nxt = state;
    case (state)
      ERR1:    state_nxt = ERR2;
      FWD: begin
        if (m_hready) begin
          if (!xfer_valid)  state_nxt = IDLE;
          else if (addr_ok) state_nxt = FWD;
          else              state_nxt = ERR1;
        end
      end
      default: begin
        if (!xfer_valid)  state_nxt = IDLE;
        else if (addr_ok) state_nxt = FWD;
        else              state_nxt = ERR1;
      end
    endcase
  end

  // Data-phase response back to the master.
  always_comb begin
    s_hready = 1'b1;
    s_hresp  = 2'b00;
    s_hrdata = '0;
    case (state)
      FWD: begin
        s_hready = m_hready;
        s_hresp  = m_hresp;
        s_hrdata = m_hrdata;
      end
      ERR1: begin
        s_hready = 1'b0;
        s_hresp  = 2'b01;
      end
      ERR2:    s_hresp = 2'b01;
      default: ;
    endcase
  end

  // Only m_hsel/m_htrans gate the downstream slave; the rest can pass through unconditionally.
  always_comb begin
    m_hsel   = xfer_valid & addr_ok;
    m_htrans = m_hsel ? s_htrans : 2'b00;
    m_hburst = s_hburst;
    m_hsize  = s_hsize;
    m_hwrite = s_hwrite;
    m_haddr  = s_haddr;
    m_hwdata = s_hwdata;
  end

`ifdef ADDR_FILTER_STATS_EN
  always_ff @(posedge hclk) begin
    if (hresetn)
      blocked_cnt <= 16'd0;
    else if (xfer_valid && !addr_ok && (blocked_cnt != 16'hFFFF))
      blocked_cnt <= blocked_cnt + 16'd1;
  end
`endif

endmodule

// File: tb/tb_modport_top.sv
// Bench for modport_top: directed scenarios plus randomized traffic against a transaction-level model.
// Covers the blocked-transfer counter when ADDR_FILTER_STATS_EN is defined.
`timescale 1ns/1ps

module tb_modport_top;
  localparam longint BASE  = 64'h0000_0000;
  localparam longint LIMIT = 64'h0000_FFFF;

  logic        hclk;
  logic        hresetn;
  logic        s_hsel;
  logic [1:0]  s_htrans;
  logic [2:0]  s_hburst;
  logic [2:0]  s_hsize;
  logic        s_hwrite;
  logic [31:0] s_haddr;
  logic [31:0] s_hwdata;
  logic [31:0] s_hrdata;
  logic        s_hready;
  logic [1:0]  s_hresp;
  logic        m_hsel;
  logic [1:0]  m_htrans;
  logic [2:0]  m_hburst;
  logic [2:0]  m_hsize;
  logic        m_hwrite;
  logic [31:0] m_haddr;
  logic [31:0] m_hwdata;
  logic [31:0] m_hrdata;
  logic        m_hready;
  logic [1:0]  m_hresp;
  logic [1:0]  fsm_state;
`ifdef ADDR_FILTER_STATS_EN
  logic [15:0] blocked_cnt;
`endif

  int checks = 0;
  int errors = 0;
  logic [2:0] exp_q[$];   // pending ERROR data-phase beats as {hready, hresp}

  modport_top dut (
    .hclk(hclk), .hresetn(hresetn),
    .s_hsel(s_hsel), .s_htrans(s_htrans), .s_hburst(s_hburst), .s_hsize(s_hsize),
    .s_hwrite(s_hwrite), .s_haddr(s_haddr), .s_hwdata(s_hwdata),
    .s_hrdata(s_hrdata), .s_hready(s_hready), .s_hresp(s_hresp),
    .m_hsel(m_hsel), .m_htrans(m_htrans), .m_hburst(m_hburst), .m_hsize(m_hsize),
    .m_hwrite(m_hwrite), .m_haddr(m_haddr), .m_hwdata(m_hwdata),
    .m_hrdata(m_hrdata), .m_hready(m_hready), .m_hresp(m_hresp),
`ifdef ADDR_FILTER_STATS_EN
    .blocked_cnt(blocked_cnt),
`endif
    .fsm_state(fsm_state)
  );

  initial begin
    hclk = 1'b0;
    forever #5 hclk = ~hclk;
  end

  task automatic step();
    @(posedge hclk);
    #1;
  endtask

  task automatic drive_idle();
    s_hsel   = 1'b0;
    s_htrans = 2'b00;
    s_hburst = 3'b000;
    s_hsize  = 3'b010;
    s_hwrite = 1'b0;
    s_haddr  = 32'h0;
  endtask

  task automatic drive_addr(input logic [1:0] trans, input logic wr, input logic [31:0] addr,
                            input logic [2:0] burst);
    s_hsel   = 1'b1;
    s_htrans = trans;
    s_hburst = burst;
    s_hsize  = 3'b010;
    s_hwrite = wr;
    s_haddr  = addr;
  endtask

  task automatic apply_reset();
    hresetn  = 1'b1;
    drive_idle();
    m_hready = 1'b1;
    m_hresp  = 2'b00;
    step();
    step();
    hresetn  = 1'b0;
  endtask

  task automatic test_reset();
    hresetn  = 1'b1;
    drive_idle();
    s_hwdata = 32'h0;
    m_hready = 1'b1;
    m_hresp  = 2'b00;
    m_hrdata = 32'hA5A5_5A5A;
    step();
    step();
    @(negedge hclk);
    checks++; if (s_hready !== 1'b1) begin errors++; $display("FAIL reset_hready: got %0b expected 1", s_hready); end
    checks++; if (s_hresp !== 2'b00) begin errors++; $display("FAIL reset_hresp: got %0b expected 00", s_hresp); end
    checks++; if (m_htrans !== 2'b00) begin errors++; $display("FAIL reset_mhtrans: got %0b expected 00", m_htrans); end
    checks++; if (m_hsel !== 1'b0) begin errors++; $display("FAIL reset_mhsel: got %0b expected 0", m_hsel); end
    checks++; if (s_hrdata !== 32'h0) begin errors++; $display("FAIL reset_hrdata: got %0h expected 0", s_hrdata); end
    checks++; if (fsm_state !== 2'd0) begin errors++; $display("FAIL reset_state: got %0d expected 0", fsm_state); end
`ifdef ADDR_FILTER_STATS_EN
    checks++; if (blocked_cnt !== 16'd0) begin errors++; $display("FAIL reset_cnt: got %0d expected 0", blocked_cnt); end
`endif
    hresetn = 1'b0;
  endtask

  task automatic test_pass_write();
    step();
    drive_addr(2'b10, 1'b1, 32'h0000_0010, 3'b000);
    @(negedge hclk);
    checks++; if (m_hsel !== 1'b1 || m_htrans !== 2'b10) begin errors++; $display("FAIL wr_fwd: got sel=%0b trans=%0b expected 1/10", m_hsel, m_htrans); end
    checks++; if (m_haddr !== 32'h10 || m_hwrite !== 1'b1) begin errors++; $display("FAIL wr_addr: got %0h/%0b expected 10/1", m_haddr, m_hwrite); end
    checks++; if (s_hready !== 1'b1) begin errors++; $display("FAIL wr_addr_ready: got %0b expected 1", s_hready); end
    step();
    drive_idle();
    s_hwdata = 32'hDEAD_BEEF;
    @(negedge hclk);
    checks++; if (m_hwdata !== 32'hDEAD_BEEF) begin errors++; $display("FAIL wr_data: got %0h expected deadbeef", m_hwdata); end
    checks++; if (s_hready !== 1'b1 || s_hresp !== 2'b00) begin errors++; $display("FAIL wr_rsp: got %0b/%0b expected 1/00", s_hready, s_hresp); end
    checks++; if (m_htrans !== 2'b00) begin errors++; $display("FAIL wr_idle_trans: got %0b expected 00", m_htrans); end
  endtask

  task automatic test_blocked_read();
    m_hrdata = 32'hCAFE_F00D;
    step();
    drive_addr(2'b10, 1'b0, 32'h0001_0000, 3'b000);
    @(negedge hclk);
    checks++; if (m_htrans !== 2'b00 || m_hsel !== 1'b0) begin errors++; $display("FAIL blk_gate: got trans=%0b sel=%0b expected 00/0", m_htrans, m_hsel); end
    step();
    drive_idle();
    @(negedge hclk);
    checks++; if (s_hready !== 1'b0 || s_hresp !== 2'b01) begin errors++; $display("FAIL blk_err1: got %0b/%0b expected 0/01", s_hready, s_hresp); end
    step();
    @(negedge hclk);
    checks++; if (s_hready !== 1'b1 || s_hresp !== 2'b01) begin errors++; $display("FAIL blk_err2: got %0b/%0b expected 1/01", s_hready, s_hresp); end
    checks++; if (s_hrdata !== 32'h0) begin errors++; $display("FAIL blk_rdata: got %0h expected 0", s_hrdata); end
    step();
    @(negedge hclk);
    checks++; if (s_hready !== 1'b1 || s_hresp !== 2'b00) begin errors++; $display("FAIL blk_after: got %0b/%0b expected 1/00", s_hready, s_hresp); end
  endtask

  task automatic test_wait_read();
    step();
    drive_addr(2'b10, 1'b0, 32'h0000_FFFF, 3'b000);
    m_hready = 1'b1;
    @(negedge hclk);
    checks++; if (m_hsel !== 1'b1 || m_haddr !== 32'h0000_FFFF) begin errors++; $display("FAIL wait_fwd: got sel=%0b addr=%0h expected 1/ffff", m_hsel, m_haddr); end
    for (int i = 0; i < 2; i++) begin
      step();
      drive_idle();
      m_hready = 1'b0;
      m_hrdata = $urandom;
      @(negedge hclk);
      checks++; if (s_hready !== 1'b0) begin errors++; $display("FAIL wait_stall%0d: got %0b expected 0", i, s_hready); end
    end
    step();
    m_hready = 1'b1;
    m_hrdata = 32'h1234_5678;
    @(negedge hclk);
    checks++; if (s_hready !== 1'b1 || s_hrdata !== 32'h1234_5678) begin errors++; $display("FAIL wait_done: got %0b/%0h expected 1/12345678", s_hready, s_hrdata); end
  endtask

  task automatic test_burst();
    apply_reset();
    drive_addr(2'b10, 1'b0, 32'h0000_FFF8, 3'b011);
    @(negedge hclk);
    checks++; if (m_hsel !== 1'b1 || m_htrans !== 2'b10 || m_haddr !== 32'hFFF8) begin errors++; $display("FAIL burst_b0: got %0b/%0b/%0h expected 1/10/fff8", m_hsel, m_htrans, m_haddr); end
    step();
    drive_addr(2'b11, 1'b0, 32'h0000_FFFC, 3'b011);
    @(negedge hclk);
    checks++; if (m_hsel !== 1'b1 || m_htrans !== 2'b11 || m_haddr !== 32'hFFFC) begin errors++; $display("FAIL burst_b1: got %0b/%0b/%0h expected 1/11/fffc", m_hsel, m_htrans, m_haddr); end
    step();
    drive_addr(2'b11, 1'b0, 32'h0001_0000, 3'b011);
    @(negedge hclk);
    checks++; if (m_hsel !== 1'b0 || m_htrans !== 2'b00) begin errors++; $display("FAIL burst_b2_gate: got %0b/%0b expected 0/00", m_hsel, m_htrans); end
    checks++; if (s_hready !== 1'b1 || s_hresp !== 2'b00) begin errors++; $display("FAIL burst_b1_rsp: got %0b/%0b expected 1/00", s_hready, s_hresp); end
    step();
    drive_idle();
    @(negedge hclk);
    checks++; if (s_hready !== 1'b0 || s_hresp !== 2'b01) begin errors++; $display("FAIL burst_err1: got %0b/%0b expected 0/01", s_hready, s_hresp); end
`ifdef ADDR_FILTER_STATS_EN
    checks++; if (blocked_cnt !== 16'd1) begin errors++; $display("FAIL burst_cnt: got %0d expected 1", blocked_cnt); end
`endif
    step();
    @(negedge hclk);
    checks++; if (s_hready !== 1'b1 || s_hresp !== 2'b01) begin errors++; $display("FAIL burst_err2: got %0b/%0b expected 1/01", s_hready, s_hresp); end
  endtask

  task automatic test_reset_abort();
    step();
    drive_addr(2'b10, 1'b1, 32'h8000_0000, 3'b000);
    step();
    drive_idle();
    hresetn = 1'b1;
    @(negedge hclk);
    checks++; if (s_hready !== 1'b0) begin errors++; $display("FAIL abort_err1: got %0b expected 0", s_hready); end
    step();
    hresetn = 1'b0;
    @(negedge hclk);
    checks++; if (s_hready !== 1'b1 || s_hresp !== 2'b00) begin errors++; $display("FAIL abort_idle: got %0b/%0b expected 1/00", s_hready, s_hresp); end
  endtask

  task automatic test_random(input int n);
    bit          fwd_pending;
    int          exp_blocked;
    logic [2:0]  exp_rsp;
    logic [31:0] exp_rdata;
    bit          accept;
    bit          in_range;
    longint      a;
    fwd_pending = 1'b0;
    exp_blocked = 0;
    exp_q.delete();
    hresetn = 1'b1;
    drive_idle();
    step();
    hresetn = 1'b0;
    for (int c = 0; c < n; c++) begin
      step();
      case ($urandom_range(0, 3))
        0: s_haddr = $urandom;
        1: s_haddr = 32'h0000_FFF0 + 32'($urandom_range(0, 31));
        2: s_haddr = 32'($urandom_range(0, 16'hFFFF));
        default: s_haddr = 32'h0001_0000 + 32'($urandom_range(0, 255));
      endcase
      s_hsel   = ($urandom_range(0, 3) != 0);
      s_htrans = 2'($urandom_range(0, 3));
      s_hburst = 3'($urandom_range(0, 7));
      s_hsize  = 3'($urandom_range(0, 2));
      s_hwrite = 1'($urandom_range(0, 1));
      s_hwdata = $urandom;
      m_hready = ($urandom_range(0, 3) != 0);
      m_hresp  = ($urandom_range(0, 7) == 0) ? 2'b01 : 2'b00;
      m_hrdata = $urandom;
      @(negedge hclk);
      if (exp_q.size() > 0) begin
        exp_rsp   = exp_q[0];
        exp_rdata = 32'h0;
      end else if (fwd_pending) begin
        exp_rsp   = {m_hready, m_hresp};
        exp_rdata = m_hrdata;
      end else begin
        exp_rsp   = 3'b100;
        exp_rdata = 32'h0;
      end
      a        = longint'(s_haddr);
      in_range = (a >= BASE) && (a <= LIMIT);
      accept   = exp_rsp[2] && s_hsel && s_htrans[1];
      checks++; if ({s_hready, s_hresp} !== exp_rsp) begin errors++; $display("FAIL rnd_rsp c%0d: got %0b/%0b expected %0b", c, s_hready, s_hresp, exp_rsp); end
      checks++; if (s_hrdata !== exp_rdata) begin errors++; $display("FAIL rnd_rdata c%0d: got %0h expected %0h", c, s_hrdata, exp_rdata); end
      checks++; if (m_hsel !== (accept && in_range) || m_htrans !== ((accept && in_range) ? s_htrans : 2'b00)) begin
        errors++; $display("FAIL rnd_fwd c%0d: got sel=%0b trans=%0b expected sel=%0b", c, m_hsel, m_htrans, accept && in_range);
      end
      if (accept && in_range) begin
        checks++; if (m_haddr !== s_haddr || m_hwrite !== s_hwrite || m_hburst !== s_hburst || m_hsize !== s_hsize) begin
          errors++; $display("FAIL rnd_ctrl c%0d: got %0h expected %0h", c, m_haddr, s_haddr);
        end
      end
      checks++; if (m_hwdata !== s_hwdata) begin errors++; $display("FAIL rnd_wdata c%0d: got %0h expected %0h", c, m_hwdata, s_hwdata); end
`ifdef ADDR_FILTER_STATS_EN
      checks++; if (blocked_cnt !== 16'(exp_blocked)) begin errors++; $display("FAIL rnd_cnt c%0d: got %0d expected %0d", c, blocked_cnt, exp_blocked); end
`endif
      if (exp_q.size() > 0) void'(exp_q.pop_front());
      if (accept) begin
        fwd_pending = in_range;
        if (!in_range) begin
          exp_q.push_back(3'b001);
          exp_q.push_back(3'b101);
          if (exp_blocked < 65535) exp_blocked++;
        end
      end else if (exp_rsp[2]) begin
        fwd_pending = 1'b0;
      end
    end
  endtask

  initial begin
    test_reset();
    test_pass_write();
    test_blocked_read();
    test_wait_read();
    test_burst();
    test_reset_abort();
    test_random(3000);
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
